result_collector: RTL and testbench
===================================

# result_collector

Parametrised in-order result retirement stage. Sits between the floating-point functional units (add, mul, sine, and any added later) and the CPU-facing output port. Reads the issued-op tag stream from the op FIFO and waits for the addressed unit's `done`. It then captures that unit's result into an internal output buffer, acknowledges the unit with a one-cycle `serv` pulse, and pops the tag. The CPU drains the buffer with `cpu_pop`.

## Interface
- `NUM_UNITS`, 3: number of functional units. Index 0 = add, 1 = mul, 2 = sine.
- `DATA_W`, 32: result width.
- `TAG_W`, 3: op-tag width. 2**TAG_W >= NUM_UNITS.
- `OUT_DEPTH`, 4: output buffer entries. Power of two, >= 2.
- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `unit_result`  in  NUM_UNITS*DATA_W  flattened results; unit i occupies bits [i*DATA_W +: DATA_W].
- `unit_done`  in  NUM_UNITS  unit i result valid. Held, with its result stable, until `unit_serv[i]`.
- `unit_serv`  out  NUM_UNITS  one-cycle acknowledge to unit i.
- `tag_fifo_out`  in  TAG_W  head-of-FIFO unit index (show-ahead).
- `tag_fifo_empty`  in  1  op FIFO empty.
- `tag_fifo_pop`  out  1  one-cycle pop of op FIFO.
- `cpu_pop`  in  1  CPU consumes `result`. Ignored when `result_valid`=0.
- `result`  out  DATA_W  head of output buffer. 0 when empty.
- `result_valid`  out  1  output buffer non-empty.
- `out_fifo_hold`  out  1  output buffer full.
- `out_count`  out  $clog2(OUT_DEPTH+1)  buffered entries.
- `tag_err`  out  1  sticky: a tag >= NUM_UNITS was seen.

## Operation
- Reset values:
  - FSM = IDLE.
  - `unit_serv`, `tag_fifo_pop`, `result_valid`, `out_fifo_hold`, `tag_err` = 0.
  - `out_count` = 0; `result` = 0.
  - Buffer pointers = 0; buffered data discarded.
- FSM states (Moore outputs):
  - IDLE: if `tag_fifo_empty`=0, go to WAIT.
  - WAIT: sample `tag_fifo_out` as t.
    - If t >= NUM_UNITS: latch t, go to DISCARD.
    - Else if `unit_done[t]`=1 and `out_fifo_hold`=0: write `unit_result[t]` to the buffer, latch t, go to ACK.
    - Else stay in WAIT. Done from non-head units is ignored; completion is strictly in issue order.
  - ACK: `unit_serv[t_latched]`=1 and `tag_fifo_pop`=1 for exactly this cycle. Next state is WAIT if `tag_fifo_empty`=0, else IDLE. `tag_fifo_empty` is sampled pre-pop; that is safe because WAIT re-checks it.
  - DISCARD: `tag_fifo_pop`=1, `tag_err` set (sticky until reset), no buffer write, no serv. Next state follows the same rule as ACK.
- Rule for WAIT: if WAIT sees `tag_fifo_empty`=1, it returns to IDLE.
- Output buffer:
  - Circular FIFO with show-ahead.
  - `result_valid` = (count != 0); `out_fifo_hold` = (count == OUT_DEPTH).
  - Pointers wrap modulo OUT_DEPTH.
- Simultaneous write and `cpu_pop`: both take effect and count is unchanged.
- Full buffer: capture is blocked even if `cpu_pop` is asserted in the same cycle. The write proceeds on the next WAIT evaluation.
- `cpu_pop` while empty: no effect, no underflow.
- `n_rst` mid-operation: all outputs drop immediately (asynchronous). In-flight `serv`/`pop` pulses are truncated and buffered results are lost.

## Timing
- Capture latency: `unit_done[t]` sampled high in WAIT at edge k → buffer written at k. In cycle k..k+1:
  - `result_valid` is high if the buffer was empty;
  - `unit_serv[t]` and `tag_fifo_pop` are high.
- Throughput: one retirement per 2 cycles (WAIT→ACK→WAIT).
- Units must deassert `done` by the edge ending ACK; a `done` still high in the next WAIT is treated as the next op's completion only if the new head tag matches.
- `cpu_pop` at edge k → next entry on `result` after k.
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths except `result`, which is a mux from registered buffer storage.

## Structure
- Package `result_collector_pkg`:
  - `rc_state_t` enum {IDLE, WAIT, ACK, DISCARD};
  - unit index constants `UNIT_ADD`=0, `UNIT_MUL`=1, `UNIT_SINE`=2.
- Sub-module `rc_out_fifo` (DATA_W, OUT_DEPTH):
  - ports: write enable, read enable, data in, head data, count, empty, full.
  - `result_collector` owns only the FSM, tag latch, unit mux and `tag_err`.

## Test plan
- Reset: hold `n_rst`=0 with `unit_done`=3'b111 → every output stays 0.
- Single op: tag 0, `unit_result[0]`=32'h0000_0001, `unit_done[0]`=1.
  - `unit_serv`=3'b001 for one cycle, together with `tag_fifo_pop`.
  - `result`=32'h1, `result_valid`=1.
- Out-of-order completion: tags 2,0 queued; unit 0 done first, unit 2 done 5 cycles later.
  - Nothing is served until unit 2 completes.
  - Buffer order is sine result, then add result.
- Full buffer: 4 ops complete with no `cpu_pop`.
  - `out_fifo_hold`=1 and `out_count`=4; the 5th op stalls in WAIT with no serv.
  - One `cpu_pop` → the 5th op is captured within 2 cycles.
- Bad tag 3'b101: `tag_fifo_pop` pulses, `tag_err`=1 and stays 1, no serv, `out_count` unchanged.
- Reset mid-ACK: assert `n_rst`=0 during the `unit_serv` cycle.
  - Serv drops immediately; `out_count`=0 after release.

Source files
------------

// File: rtl/result_collector_pkg.sv
// Shared types and constants for the in-order result retirement stage.
package result_collector_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACK     = 2'd2,
        DISCARD = 2'd3
    } rc_state_t;

    localparam int UNIT_ADD  = 0;
    localparam int UNIT_MUL  = 1;
    localparam int UNIT_SINE = 2;

endpackage

// File: rtl/rc_out_fifo.sv
// Show-ahead circular buffer holding retired results until the CPU drains them.
// Reads a zero head when empty so the CPU port never shows stale data.
module rc_out_fifo
    import result_collector_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int OUT_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           wr_en,
    input  logic                           rd_en,
    input  logic [DATA_W-1:0]              wr_data,
    output logic [DATA_W-1:0]              rd_data,
    output logic [$clog2(OUT_DEPTH+1)-1:0] count,
    output logic                           empty,
    output logic                           full
);

    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUT_DEPTH);

    logic [DATA_W-1:0] mem [OUT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_do;
    logic              rd_do;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign wr_do = wr_en && !full;
    assign rd_do = rd_en && !empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_do) wr_ptr <= wr_ptr + 1'b1;
            if (rd_do) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_do, rd_do})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_do) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/result_collector.sv
// In-order retirement: waits on the unit named by the head op tag, captures its
// result into the output buffer, then acknowledges the unit and pops the tag.
//
// state   | meaning
// IDLE    | op FIFO empty, nothing to retire
// WAIT    | head tag sampled; waiting for that unit's done and buffer space
// ACK     | result captured; serv to the unit and pop the tag this cycle
// DISCARD | head tag names no unit; pop it and flag tag_err
module result_collector
    import result_collector_pkg::*;
#(
    parameter int NUM_UNITS = 3,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 3,
    parameter int OUT_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic [NUM_UNITS*DATA_W-1:0]    unit_result,
    input  logic [NUM_UNITS-1:0]           unit_done,
    output logic [NUM_UNITS-1:0]           unit_serv,
    input  logic [TAG_W-1:0]               tag_fifo_out,
    input  logic                           tag_fifo_empty,
    output logic                           tag_fifo_pop,
    input  logic                           cpu_pop,
    output logic [DATA_W-1:0]              result,
    output logic                           result_valid,
    output logic                           out_fifo_hold,
    output logic [$clog2(OUT_DEPTH+1)-1:0] out_count,
    output logic                           tag_err
);

    rc_state_t         state_q;
    rc_state_t         state_d;
    logic [TAG_W-1:0]  tag_q;
    logic              tag_bad;
    logic              sel_done;
    logic [DATA_W-1:0] sel_result;
    logic              capture;
    logic              latch_tag;
    logic              buf_empty;
    logic              buf_full;
    logic              tag_err_q;

    // Unit mux; a tag matching no unit is flagged rather than indexed out of range.
    always_comb begin
        sel_done   = 1'b0;
        sel_result = '0;
        tag_bad    = 1'b1;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (tag_fifo_out == TAG_W'(i)) begin
                sel_done   = unit_done[i];
                sel_result = unit_result[i*DATA_W +: DATA_W];
                tag_bad    = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (!tag_fifo_empty) state_d = WAIT;
            end
            WAIT: begin
                if (tag_fifo_empty) begin
                    state_d = IDLE;
                end else if (tag_bad) begin
                    state_d = DISCARD;
                end else if (sel_done && !buf_full) begin
                    capture = 1'b1;
                    state_d = ACK;
                end
            end
            // Empty is seen pre-pop here; WAIT re-checks it next cycle.
            ACK, DISCARD: begin
                state_d = tag_fifo_empty ? IDLE : WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    assign latch_tag = (state_q == WAIT) && ((state_d == ACK) || (state_d == DISCARD));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            tag_q     <= '0;
            tag_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_tag) tag_q <= tag_fifo_out;
            if (state_d == DISCARD) tag_err_q <= 1'b1;
        end
    end

    always_comb begin
        unit_serv = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            unit_serv[i] = (state_q == ACK) && (tag_q == TAG_W'(i));
        end
    end

    assign tag_fifo_pop  = (state_q == ACK) || (state_q == DISCARD);
    assign tag_err       = tag_err_q;
    assign result_valid  = !buf_empty;
    assign out_fifo_hold = buf_full;

    rc_out_fifo #(
        .DATA_W    (DATA_W),
        .OUT_DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .wr_en   (capture),
        .rd_en   (cpu_pop),
        .wr_data (sel_result),
        .rd_data (result),
        .count   (out_count),
        .empty   (buf_empty),
        .full    (buf_full)
    );

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: models the op FIFO and unit handshakes,
// checks retirement order, buffer limits, bad tags and reset.
module tb_result_collector;
    import result_collector_pkg::*;

    localparam int NU = 3;
    localparam int DW = 32;
    localparam int TW = 3;
    localparam int OD = 4;

    logic            clk = 1'b0;
    logic            n_rst;
    logic [NU*DW-1:0] unit_result;
    logic [NU-1:0]   unit_done;
    logic [NU-1:0]   unit_serv;
    logic [TW-1:0]   tag_fifo_out;
    logic            tag_fifo_empty;
    logic            tag_fifo_pop;
    logic            cpu_pop;
    logic [DW-1:0]   result;
    logic            result_valid;
    logic            out_fifo_hold;
    logic [2:0]      out_count;
    logic            tag_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [TW-1:0] tq[$];

    result_collector #(
        .NUM_UNITS (NU),
        .DATA_W    (DW),
        .TAG_W     (TW),
        .OUT_DEPTH (OD)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .unit_result    (unit_result),
        .unit_done      (unit_done),
        .unit_serv      (unit_serv),
        .tag_fifo_out   (tag_fifo_out),
        .tag_fifo_empty (tag_fifo_empty),
        .tag_fifo_pop   (tag_fifo_pop),
        .cpu_pop        (cpu_pop),
        .result         (result),
        .result_valid   (result_valid),
        .out_fifo_hold  (out_fifo_hold),
        .out_count      (out_count),
        .tag_err        (tag_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function void refresh();
        tag_fifo_empty = (tq.size() == 0);
        tag_fifo_out   = (tq.size() == 0) ? '0 : tq[0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tag(input logic [TW-1:0] t);
        tq.push_back(t);
        refresh();
    endtask

    // Show-ahead op FIFO model: pop applied just after the edge that saw tag_fifo_pop.
    always @(posedge clk) begin
        if (tag_fifo_pop) begin
            #1;
            if (tq.size() > 0) tq.delete(0);
            refresh();
        end
    end

    // Waits for a serv pulse; the served unit drops done during its ACK cycle.
    task automatic wait_serv(input int limit, output logic [NU-1:0] s);
        s = '0;
        for (int c = 0; c < limit; c++) begin
            tick();
            if (unit_serv != '0) begin
                s = unit_serv;
                unit_done = unit_done & ~unit_serv;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NU-1:0] s;
        int pops;
        int servs;

        n_rst       = 1'b0;
        cpu_pop     = 1'b0;
        unit_done   = 3'b111;
        unit_result = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        push_tag(3'd0);

        // reset holds every output low even with units and FIFO active
        repeat (3) tick();
        chk("rst_serv",  32'(unit_serv), 32'h0);
        chk("rst_pop",   32'(tag_fifo_pop), 32'h0);
        chk("rst_valid", 32'(result_valid), 32'h0);
        chk("rst_hold",  32'(out_fifo_hold), 32'h0);
        chk("rst_count", 32'(out_count), 32'h0);
        chk("rst_err",   32'(tag_err), 32'h0);
        chk("rst_result", result, 32'h0);

        unit_done = '0;
        tq.delete();
        refresh();
        tick();
        n_rst = 1'b1;
        tick();

        // single op on the add unit, exact latency
        push_tag(3'(UNIT_ADD));
        unit_result[0 +: DW] = 32'h0000_0001;
        unit_done[UNIT_ADD]  = 1'b1;
        tick();
        chk("single_wait_serv", 32'(unit_serv), 32'h0);
        tick();
        chk("single_serv",   32'(unit_serv), 32'h1);
        chk("single_pop",    32'(tag_fifo_pop), 32'h1);
        chk("single_result", result, 32'h1);
        chk("single_valid",  32'(result_valid), 32'h1);
        unit_done[UNIT_ADD] = 1'b0;
        tick();
        chk("single_serv_end", 32'(unit_serv), 32'h0);
        chk("single_pop_end",  32'(tag_fifo_pop), 32'h0);
        cpu_pop = 1'b1;
        tick();
        cpu_pop = 1'b0;
        chk("single_drain_valid",  32'(result_valid), 32'h0);
        chk("single_drain_result", result, 32'h0);

        // out-of-order completion: head is sine, add finishes first
        push_tag(3'(UNIT_SINE));
        push_tag(3'(UNIT_ADD));
        unit_result[UNIT_SINE*DW +: DW] = 32'h5111_E002;
        unit_result[UNIT_ADD*DW +: DW]  = 32'hADD0_0000;
        unit_done[UNIT_ADD] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("ooo_hold_serv", 32'(unit_serv), 32'h0);
        end
        chk("ooo_hold_count", 32'(out_count), 32'h0);
        unit_done[UNIT_SINE] = 1'b1;
        wait_serv(4, s);
        chk("ooo_first_serv", 32'(s), 32'h4);
        wait_serv(4, s);
        chk("ooo_second_serv", 32'(s), 32'h1);
        chk("ooo_count", 32'(out_count), 32'h2);
        chk("ooo_head_sine", result, 32'h5111_E002);
        cpu_pop = 1'b1;
        tick();
        cpu_pop = 1'b0;
        chk("ooo_head_add", result, 32'hADD0_0000);
        cpu_pop = 1'b1;
        tick();
        cpu_pop = 1'b0;
        chk("ooo_empty", 32'(result_valid), 32'h0);

        // fill the buffer through the mul unit
        for (int k = 0; k < OD; k++) begin
            push_tag(3'(UNIT_MUL));
            unit_result[UNIT_MUL*DW +: DW] = 32'hA0 + 32'(k);
            unit_done[UNIT_MUL] = 1'b1;
            wait_serv(8, s);
            chk("fill_serv", 32'(s), 32'h2);
        end
        chk("full_hold",  32'(out_fifo_hold), 32'h1);
        chk("full_count", 32'(out_count), 32'h4);

        // fifth op stalls while full
        push_tag(3'(UNIT_MUL));
        unit_result[UNIT_MUL*DW +: DW] = 32'hA4;
        unit_done[UNIT_MUL] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("stall_serv", 32'(unit_serv), 32'h0);
        end
        chk("stall_count", 32'(out_count), 32'h4);

        // pop on a full buffer frees a slot; the next edge writes and pops together
        cpu_pop = 1'b1;
        tick();
        chk("unstall_wait_serv", 32'(unit_serv), 32'h0);
        chk("unstall_count1",    32'(out_count), 32'h3);
        tick();
        chk("unstall_serv",   32'(unit_serv), 32'h2);
        chk("unstall_count2", 32'(out_count), 32'h3);
        chk("unstall_head",   result, 32'hA2);
        cpu_pop = 1'b0;
        unit_done[UNIT_MUL] = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            chk("drain_order", result, 32'hA0 + 32'(k));
            cpu_pop = 1'b1;
            tick();
            cpu_pop = 1'b0;
        end
        chk("drain_valid", 32'(result_valid), 32'h0);
        chk("drain_count", 32'(out_count), 32'h0);
        cpu_pop = 1'b1;
        tick();
        cpu_pop = 1'b0;
        chk("underflow_count", 32'(out_count), 32'h0);

        // bad tag is popped and flagged without touching units or buffer
        push_tag(3'b101);
        pops  = 0;
        servs = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (tag_fifo_pop) pops++;
            if (unit_serv != '0) servs++;
        end
        chk("bad_pops",  32'(pops), 32'h1);
        chk("bad_servs", 32'(servs), 32'h0);
        chk("bad_err",   32'(tag_err), 32'h1);
        chk("bad_count", 32'(out_count), 32'h0);
        repeat (3) tick();
        chk("bad_err_sticky", 32'(tag_err), 32'h1);

        // reset asserted during ACK truncates the pulse and drops the buffer
        push_tag(3'(UNIT_ADD));
        unit_result[UNIT_ADD*DW +: DW] = 32'h55;
        unit_done[UNIT_ADD] = 1'b1;
        wait_serv(6, s);
        chk("rack_serv_seen", 32'(s), 32'h1);
        n_rst = 1'b0;
        #1;
        chk("rack_serv",  32'(unit_serv), 32'h0);
        chk("rack_pop",   32'(tag_fifo_pop), 32'h0);
        chk("rack_valid", 32'(result_valid), 32'h0);
        chk("rack_err",   32'(tag_err), 32'h0);
        tq.delete();
        refresh();
        unit_done = '0;
        tick();
        n_rst = 1'b1;
        tick();
        tick();
        chk("rack_count_after", 32'(out_count), 32'h0);
        chk("rack_pop_after",   32'(tag_fifo_pop), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
